// File: rtl/store_buffer_if.sv
// store_buffer_if: bundles the store-buffer handshake and lookup signals.
//
// The master modport is the pipeline/cache side. It issues stores, loads,
// retires and squashes, and it accepts drain writes. The slave modport is
// the store buffer itself.
//
// Signal groups:
//   st_*          store enqueue (valid/ready)
//   ld_* / fwd_*  combinational store-to-load forwarding lookup
//   ret_*         in-order retire of the oldest speculative store
//   squash        discard every speculative store
//   drain_*       committed head write to d_cache (valid/ready)
//   count/empty   occupancy
//   dbg_*         raw head/cmt/tail pointers, wrap bit included
interface store_buffer_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 20
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic                  st_valid;
    logic                  st_ready;
    logic [ID_WIDTH-1:0]   st_id;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  ret_valid;
    logic [ID_WIDTH-1:0]   ret_id;
    logic                  ret_err;

    logic                  squash;

    logic                  drain_valid;
    logic                  drain_ready;
    logic [ADDR_WIDTH-1:0] drain_addr;
    logic [DATA_WIDTH-1:0] drain_data;

    logic [PW-1:0]         count;
    logic                  empty;

    logic [PW-1:0]         dbg_head;
    logic [PW-1:0]         dbg_cmt;
    logic [PW-1:0]         dbg_tail;

    modport master (
        output st_valid, st_id, st_addr, st_data,
        output ld_valid, ld_addr,
        output ret_valid, ret_id, squash, drain_ready,
        input  st_ready, fwd_hit, fwd_data, ret_err,
        input  drain_valid, drain_addr, drain_data,
        input  count, empty, dbg_head, dbg_cmt, dbg_tail
    );

    modport slave (
        input  st_valid, st_id, st_addr, st_data,
        input  ld_valid, ld_addr,
        input  ret_valid, ret_id, squash, drain_ready,
        output st_ready, fwd_hit, fwd_data, ret_err,
        output drain_valid, drain_addr, drain_data,
        output count, empty, dbg_head, dbg_cmt, dbg_tail
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer that sits between EX/MEM and d_cache.
//
// Lifecycle of a store:
//   1. It enters the buffer as a speculative entry.
//   2. It becomes committed when it retires in order.
//   3. It drains oldest-first to the cache.
// A squash discards every speculative entry. Committed entries are never
// squashed. Loads see the youngest buffered store to the same word.
//
// Ports:
//   clk  clock
//   rst  asynchronous reset, active high; drops every entry
//   sb   store_buffer_if.slave (store/load/retire/squash/drain/occupancy)
//
// Handshakes:
//   Both st_* and drain_* follow strict valid/ready semantics. A transfer
//   happens on the rising edge where valid and ready are both high. Once
//   valid is raised, it and its payload stay stable until that edge.
//   ready never depends on valid.
//
// Pointers:
//   head, cmt and tail are $clog2(DEPTH)+1 bits; the top bit is a wrap bit.
//   Committed entries are [head,cmt). Speculative entries are [cmt,tail).
module store_buffer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 20
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] head, cmt, tail;
    logic [PW-1:0] head_nxt, cmt_nxt, tail_nxt;
    logic [PW-1:0] occ;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [ID_WIDTH-1:0]   mem_id   [DEPTH];

    logic full;
    logic enq;
    logic drain_fire;
    logic has_spec;
    logic ret_ok;
    logic ret_bad;
    logic ret_err_q;

    logic                  fwd_hit_c;
    logic [DATA_WIDTH-1:0] fwd_data_c;
    logic [IW-1:0]         fwd_slot;

    assign occ      = tail - head;
    // Same slot with different wrap bits means the buffer has lapped head.
    // A drain in the same cycle does not relieve full.
    assign full     = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
    assign has_spec = (cmt != tail);

    assign enq        = sb.st_valid & ~full & ~sb.squash;
    assign ret_ok     = sb.ret_valid & has_spec & (mem_id[cmt[IW-1:0]] == sb.ret_id);
    assign ret_bad    = sb.ret_valid & ~ret_ok;
    assign drain_fire = (head != cmt) & sb.drain_ready;

    assign head_nxt = head + {{IW{1'b0}}, drain_fire};
    assign cmt_nxt  = cmt  + {{IW{1'b0}}, ret_ok};
    // Squash collapses tail onto the post-retire cmt. A store retiring in the
    // squash cycle therefore survives, and a same-cycle enqueue is lost.
    assign tail_nxt = sb.squash ? cmt_nxt : (tail + {{IW{1'b0}}, enq});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            cmt       <= '0;
            tail      <= '0;
            ret_err_q <= 1'b0;
        end else begin
            head      <= head_nxt;
            cmt       <= cmt_nxt;
            tail      <= tail_nxt;
            ret_err_q <= ret_bad;
        end
    end

    // Entry payload needs no reset; occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[tail[IW-1:0]] <= sb.st_addr;
            mem_data[tail[IW-1:0]] <= sb.st_data;
            mem_id[tail[IW-1:0]]   <= sb.st_id;
        end
    end

    // Walk the entries from oldest to youngest so that the last match wins.
    // The lookup sees only the registered contents, so a store enqueued in
    // the same cycle is invisible. A head entry that is draining still matches.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        fwd_slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_slot = head[IW-1:0] + IW'(k);
            if (sb.ld_valid && (PW'(k) < occ) &&
                (mem_addr[fwd_slot][ADDR_WIDTH-1:2] == sb.ld_addr[ADDR_WIDTH-1:2])) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = mem_data[fwd_slot];
            end
        end
    end

    assign sb.st_ready    = ~full;
    assign sb.fwd_hit     = fwd_hit_c;
    assign sb.fwd_data    = fwd_data_c;
    assign sb.ret_err     = ret_err_q;
    assign sb.drain_valid = (head != cmt);
    assign sb.drain_addr  = mem_addr[head[IW-1:0]];
    assign sb.drain_data  = mem_data[head[IW-1:0]];
    assign sb.count       = occ;
    assign sb.empty       = (occ == '0);
    assign sb.dbg_head    = head;
    assign sb.dbg_cmt     = cmt;
    assign sb.dbg_tail    = tail;

    a_st_when_full: assert property (@(posedge clk) disable iff (rst)
        !(sb.st_valid && full))
        else $error("store_buffer: st_valid while full");

    a_drain_ready_idle: assert property (@(posedge clk) disable iff (rst)
        !(sb.drain_ready && (head == cmt)))
        else $error("store_buffer: drain_ready without drain_valid");
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios for store_buffer with DEPTH=4.
// Retired stores push their expected drain beat into exp_q. A monitor
// process pops exp_q on every drain handshake and checks that the payload
// is held stable while drain_ready is low.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int IDW   = 20;
    localparam int W     = AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) sb ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];
    int dr_mode = 0;   // 0: drain_ready low, 1: always ready, 2: alternate
    logic dr_phase = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.st_valid = 1'b1;
        sb.st_id    = id;
        sb.st_addr  = a;
        sb.st_data  = d;
        step();
        sb.st_valid = 1'b0;
    endtask

    task automatic retire(input logic [IDW-1:0] id);
        sb.ret_valid = 1'b1;
        sb.ret_id    = id;
        step();
        sb.ret_valid = 1'b0;
    endtask

    task automatic retire_ok(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
        retire(id);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!sb.empty && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(sb.empty), 64'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!sb.st_ready && n < 200) begin
            step();
            n++;
        end
        check("wait_st_ready", 64'(sb.st_ready), 64'd1);
    endtask

    // drain_ready is only ever raised while drain_valid is high
    initial begin
        sb.drain_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dr_phase = ~dr_phase;
            case (dr_mode)
                1:       sb.drain_ready = sb.drain_valid;
                2:       sb.drain_ready = sb.drain_valid & dr_phase;
                default: sb.drain_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic         hold;
        logic [W-1:0] held;
        logic [W-1:0] got;
        logic [W-1:0] e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                got = {sb.drain_addr, sb.drain_data};
                if (hold && sb.drain_valid)
                    check("drain_hold", 64'(got), 64'(held));
                if (sb.drain_valid && sb.drain_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL drain_unexpected: got 0x%0h expected no drain", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("drain_order", 64'(got), 64'(e));
                    end
                    hold = 1'b0;
                end else if (sb.drain_valid) begin
                    hold = 1'b1;
                    held = got;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        sb.st_valid  = 1'b0;
        sb.st_id     = '0;
        sb.st_addr   = '0;
        sb.st_data   = '0;
        sb.ld_valid  = 1'b0;
        sb.ld_addr   = '0;
        sb.ret_valid = 1'b0;
        sb.ret_id    = '0;
        sb.squash    = 1'b0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_count", 64'(sb.count), 64'd0);
        check("rst_empty", 64'(sb.empty), 64'd1);
        check("rst_st_ready", 64'(sb.st_ready), 64'd1);
        check("rst_drain_valid", 64'(sb.drain_valid), 64'd0);
        check("rst_fwd_hit", 64'(sb.fwd_hit), 64'd0);
        check("rst_fwd_data", 64'(sb.fwd_data), 64'd0);
        check("rst_ret_err", 64'(sb.ret_err), 64'd0);
        check("rst_tail", 64'(sb.dbg_tail), 64'd0);

        // fill to full, then retire the oldest and drain it
        for (int i = 0; i < 4; i++)
            enq(IDW'(i), AW'(32'h100 + 4 * i), DW'(i + 1));
        @(negedge clk);
        check("full_count", 64'(sb.count), 64'd4);
        check("full_st_ready", 64'(sb.st_ready), 64'd0);
        check("full_no_drain", 64'(sb.drain_valid), 64'd0);
        dr_mode = 1;
        retire_ok(IDW'(0), AW'(32'h100), DW'(1));
        @(negedge clk);
        check("first_drain_valid", 64'(sb.drain_valid), 64'd1);
        check("first_drain_addr", 64'(sb.drain_addr), 64'h100);
        check("first_drain_data", 64'(sb.drain_data), 64'd1);
        check("drain_cycle_count", 64'(sb.count), 64'd4);
        check("drain_cycle_st_ready", 64'(sb.st_ready), 64'd0);
        step();
        @(negedge clk);
        check("after_drain_count", 64'(sb.count), 64'd3);
        check("after_drain_st_ready", 64'(sb.st_ready), 64'd1);
        for (int i = 1; i < 4; i++)
            retire_ok(IDW'(i), AW'(32'h100 + 4 * i), DW'(i + 1));
        wait_empty("fill_drained");

        // forwarding picks the youngest store to the same word
        dr_mode = 0;
        enq(IDW'(10), AW'(32'h200), DW'(32'hAA));
        enq(IDW'(11), AW'(32'h200), DW'(32'hBB));
        sb.ld_valid = 1'b1;
        sb.ld_addr  = AW'(32'h202);
        @(negedge clk);
        check("fwd_young_hit", 64'(sb.fwd_hit), 64'd1);
        check("fwd_young_data", 64'(sb.fwd_data), 64'hBB);
        sb.ld_addr = AW'(32'h204);
        #1;
        check("fwd_miss_hit", 64'(sb.fwd_hit), 64'd0);
        check("fwd_miss_data", 64'(sb.fwd_data), 64'd0);
        step();
        sb.st_valid = 1'b1;
        sb.st_id    = IDW'(12);
        sb.st_addr  = AW'(32'h204);
        sb.st_data  = DW'(32'hCC);
        @(negedge clk);
        check("fwd_same_cycle_hidden", 64'(sb.fwd_hit), 64'd0);
        step();
        sb.st_valid = 1'b0;
        @(negedge clk);
        check("fwd_next_cycle_hit", 64'(sb.fwd_hit), 64'd1);
        check("fwd_next_cycle_data", 64'(sb.fwd_data), 64'hCC);
        sb.squash = 1'b1;
        step();
        sb.squash  = 1'b0;
        sb.ld_addr = AW'(32'h200);
        @(negedge clk);
        check("squash_all_count", 64'(sb.count), 64'd0);
        check("squash_all_fwd", 64'(sb.fwd_hit), 64'd0);
        sb.ld_valid = 1'b0;

        // squash keeps the committed entry only
        do_reset();
        enq(IDW'(20), AW'(32'h300), DW'(32'h31));
        enq(IDW'(21), AW'(32'h304), DW'(32'h32));
        enq(IDW'(22), AW'(32'h308), DW'(32'h33));
        retire_ok(IDW'(20), AW'(32'h300), DW'(32'h31));
        sb.squash = 1'b1;
        step();
        sb.squash   = 1'b0;
        sb.ld_valid = 1'b1;
        sb.ld_addr  = AW'(32'h304);
        @(negedge clk);
        check("sq_cmt", 64'(sb.dbg_cmt), 64'd1);
        check("sq_tail", 64'(sb.dbg_tail), 64'd1);
        check("sq_count", 64'(sb.count), 64'd1);
        check("sq_fwd_squashed", 64'(sb.fwd_hit), 64'd0);
        sb.ld_addr = AW'(32'h300);
        #1;
        check("sq_fwd_kept_hit", 64'(sb.fwd_hit), 64'd1);
        check("sq_fwd_kept_data", 64'(sb.fwd_data), 64'h31);
        sb.ld_valid = 1'b0;
        dr_mode = 1;
        wait_empty("sq_drained");

        // retire + squash + enqueue in one cycle
        dr_mode = 0;
        do_reset();
        enq(IDW'(30), AW'(32'h400), DW'(32'h41));
        enq(IDW'(31), AW'(32'h404), DW'(32'h42));
        exp_q.push_back({AW'(32'h400), DW'(32'h41)});
        sb.ret_valid = 1'b1;
        sb.ret_id    = IDW'(30);
        sb.squash    = 1'b1;
        sb.st_valid  = 1'b1;
        sb.st_id     = IDW'(32);
        sb.st_addr   = AW'(32'h408);
        sb.st_data   = DW'(32'h43);
        step();
        sb.ret_valid = 1'b0;
        sb.squash    = 1'b0;
        sb.st_valid  = 1'b0;
        sb.ld_valid  = 1'b1;
        sb.ld_addr   = AW'(32'h408);
        @(negedge clk);
        check("same_count", 64'(sb.count), 64'd1);
        check("same_cmt", 64'(sb.dbg_cmt), 64'd1);
        check("same_tail", 64'(sb.dbg_tail), 64'd1);
        check("same_ret_err", 64'(sb.ret_err), 64'd0);
        check("same_dropped_fwd", 64'(sb.fwd_hit), 64'd0);
        sb.ld_valid = 1'b0;
        dr_mode = 1;
        wait_empty("same_drained");

        // retire errors: id mismatch, then nothing left to retire
        enq(IDW'(40), AW'(32'h500), DW'(32'h51));
        retire(IDW'(41));
        @(negedge clk);
        check("err_mismatch_pulse", 64'(sb.ret_err), 64'd1);
        check("err_mismatch_cmt", 64'(sb.dbg_cmt), 64'd1);
        step();
        @(negedge clk);
        check("err_pulse_one_cycle", 64'(sb.ret_err), 64'd0);
        retire_ok(IDW'(40), AW'(32'h500), DW'(32'h51));
        @(negedge clk);
        check("err_ok_no_pulse", 64'(sb.ret_err), 64'd0);
        check("err_ok_cmt", 64'(sb.dbg_cmt), 64'd2);
        retire(IDW'(40));
        @(negedge clk);
        check("err_nothing_pulse", 64'(sb.ret_err), 64'd1);
        wait_empty("err_drained");

        // wrap-around with alternating back-pressure; pointers start at 2
        dr_mode = 2;
        for (int g = 0; g < 3; g++) begin
            for (int j = 0; j < 4; j++) begin
                wait_ready();
                enq(IDW'(100 + 4 * g + j), AW'(32'h600 + 4 * (4 * g + j)),
                    DW'(32'h1000 + 17 * (4 * g + j)));
            end
            for (int j = 0; j < 4; j++)
                retire_ok(IDW'(100 + 4 * g + j), AW'(32'h600 + 4 * (4 * g + j)),
                          DW'(32'h1000 + 17 * (4 * g + j)));
        end
        wait_empty("wrap_drained");
        @(negedge clk);
        check("wrap_head", 64'(sb.dbg_head), 64'd6);
        check("wrap_cmt", 64'(sb.dbg_cmt), 64'd6);
        check("wrap_tail", 64'(sb.dbg_tail), 64'd6);

        // asynchronous reset while a committed entry waits to drain
        dr_mode = 0;
        step();
        enq(IDW'(50), AW'(32'h700), DW'(32'h71));
        retire_ok(IDW'(50), AW'(32'h700), DW'(32'h71));
        @(negedge clk);
        check("arst_pre_valid", 64'(sb.drain_valid), 64'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_drain_valid", 64'(sb.drain_valid), 64'd0);
        check("arst_empty", 64'(sb.empty), 64'd1);
        check("arst_st_ready", 64'(sb.st_ready), 64'd1);
        check("arst_count", 64'(sb.count), 64'd0);
        step();
        rst = 1'b0;
        step();
        step();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Parametrised in-order store buffer between the EX/MEM pipeline register and d_cache.
- Stores enter speculatively, become committed when retired, and drain oldest-first to d_cache through a valid/ready handshake.
- Loads get store-to-load forwarding from the youngest matching buffered store.
- Speculative entries are discarded on squash.

Parameters:
- DEPTH, 8: number of entries; power of two, 2..32.
- ADDR_WIDTH, 26: byte address width. Matching is done on the word address [ADDR_WIDTH-1:2].
- DATA_WIDTH, 32: store data width.
- ID_WIDTH, 20: instruction id width, carried for retire checking.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- st_valid  in  1  store enqueue request
- st_ready  out  1  buffer can accept a store
- st_id  in  ID_WIDTH  store instruction id
- st_addr  in  ADDR_WIDTH  store address
- st_data  in  DATA_WIDTH  store data
- ld_valid  in  1  load lookup request
- ld_addr  in  ADDR_WIDTH  load address
- fwd_hit  out  1  a buffered store matches ld_addr
- fwd_data  out  DATA_WIDTH  data of the youngest matching store
- ret_valid  in  1  commit the oldest speculative entry
- ret_id  in  ID_WIDTH  id of the retiring store
- ret_err  out  1  registered one-cycle pulse: retire mismatch or nothing to retire
- squash  in  1  discard all speculative entries
- drain_valid  out  1  committed head entry presented to cache
- drain_ready  in  1  cache accepts the head write this cycle
- drain_addr  out  ADDR_WIDTH  head address
- drain_data  out  DATA_WIDTH  head data
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

Behaviour:
- Storage: circular array with three pointers, each $clog2(DEPTH)+1 bits wide including a wrap bit.
  - head: oldest entry.
  - cmt: first speculative entry.
  - tail: next free slot.
  - Invariant: head <= cmt <= tail, in modular order.
  - Committed entries are [head,cmt); speculative entries are [cmt,tail).
- Reset (async, rst=1): head=cmt=tail=0, count=0, empty=1, st_ready=1, drain_valid=0, fwd_hit=0, fwd_data=0, ret_err=0. Entry contents are don't-care. Reset mid-drain drops all entries, committed ones included.
- Enqueue:
  - st_ready = (count != DEPTH).
  - st_valid & st_ready & ~squash writes the entry at tail, and tail increments at the posedge.
  - Full means full: a drain in the same cycle does not raise st_ready.
- Forwarding (combinational, zero latency):
  - fwd_hit = ld_valid & any entry in [head,tail) with word address equal to ld_addr[ADDR_WIDTH-1:2].
  - fwd_data = data of the matching entry nearest tail (youngest), otherwise 0.
  - A store enqueued in the same cycle is not visible.
  - The head entry remains forwardable during the cycle it drains.
- Retire:
  - With ret_valid and cmt != tail: if the entry at cmt has id == ret_id, cmt increments. Otherwise cmt is unchanged and ret_err pulses the next cycle.
  - With ret_valid and cmt == tail: ignored, and ret_err pulses.
- Squash: tail <= cmt, after the same-cycle retire is applied, so a store retiring in the squash cycle survives. A store enqueued in the squash cycle is dropped. Committed entries are never squashed.
- Drain:
  - drain_valid = (head != cmt); drain_addr/drain_data come from the head entry.
  - drain_valid & drain_ready increments head at the posedge.
  - drain_addr/drain_data stay stable while drain_valid=1 and drain_ready=0.
- Simultaneous enqueue, retire, drain and squash in one cycle are all legal. Pointer updates use the values from before the edge. count = tail - head, computed from the next pointers.
- Wrap-around: pointers wrap modulo 2*DEPTH. Slot index = pointer[$clog2(DEPTH)-1:0]. Full when the slot bits are equal and the wrap bits differ.
- Assertions, simulation only, using $error:
  - st_valid while full.
  - drain_ready without drain_valid.

Test Plan:
- DEPTH=4. Enqueue 4 stores (A=0x100/D=1 .. 0x10C/4) with no retire -> st_ready=0 and count=4. A 5th st_valid is not accepted. Then ret_valid with ret_id=id0 and drain_ready=1 -> drain_addr=0x100, drain_data=1, and the next cycle count=3 and st_ready=1.
- Forwarding: enqueue 0x200/0xAA, then 0x200/0xBB, then ld_valid with ld_addr=0x202 -> fwd_hit=1, fwd_data=0xBB. A load of 0x204 -> fwd_hit=0, fwd_data=0.
- Squash: 3 stores, retire the first, squash -> tail=cmt=1 and count=1. Only the first store drains. A load of the squashed address gives fwd_hit=0.
- Same cycle: ret_valid for the oldest speculative entry, squash=1 and st_valid=1 -> the retired entry survives, the new store is dropped, and count equals the committed count.
- Drain back-pressure and wrap: cycle 12 stores through DEPTH=4 with drain_ready toggling 1,0 -> drain order equals enqueue order, data is held stable while drain_ready=0, and pointers wrap correctly.
- Errors and reset: ret_id mismatch -> ret_err=1 for one cycle and cmt unchanged. Assert rst while drain_valid=1 -> drain_valid=0, empty=1 and st_ready=1 immediately (async).
